// File: rtl/muldiv_pkg.sv
// Shared widths, opcode encodings and FSM state type for the muldiv request sequencer.
package muldiv_pkg;

  localparam int A_W = 32;
  localparam int B_W = 64;
  localparam int R_W = 64;

  localparam logic OP_MUL = 1'b1;
  localparam logic OP_DIV = 1'b0;

  typedef struct packed {
    logic [A_W-1:0] a;
    logic [B_W-1:0] b;
    logic           op;
  } req_t;

  localparam int REQ_W = $bits(req_t);

  typedef enum logic [2:0] {
    IDLE,
    CLR,
    LOAD,
    START,
    WAIT,
    RESP
  } state_e;

endpackage

// File: rtl/muldiv_req_fifo.sv
// Request queue: FIFO of packed requests, synchronous reset, full blocks push even on a same-cycle pop.
module muldiv_req_fifo
  import muldiv_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int WIDTH = REQ_W
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             push_valid,
  output logic             push_ready,
  input  logic [WIDTH-1:0] push_data,
  output logic             pop_valid,
  input  logic             pop_en,
  output logic [WIDTH-1:0] pop_data
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q,  count_d;
  logic             do_push,  do_pop;

  assign push_ready = (count_q != CNT_W'(DEPTH));
  assign pop_valid  = (count_q != '0);
  assign do_push    = push_valid & push_ready;
  assign do_pop     = pop_en & pop_valid;
  assign pop_data   = mem_q[rd_ptr_q];

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together at the edge.
  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // NOTE: storage is not reset; the pointers and count alone define which entries are valid.
  always_ff @(posedge clock) begin
    if (do_push) mem_q[wr_ptr_q] <= push_data;
  end

endmodule

// File: rtl/muldiv_sequencer.sv
// Queues multiply/divide requests and sequences them one at a time through an external muldiv unit.
module muldiv_sequencer
  import muldiv_pkg::*;
#(
  parameter int DEPTH   = 4,
  parameter int TIMEOUT = 200
) (
  input  logic           clock,
  input  logic           reset,
  input  logic           req_valid,
  output logic           req_ready,
  input  logic [A_W-1:0] req_a,
  input  logic [B_W-1:0] req_b,
  input  logic           req_op,
  output logic [A_W-1:0] md_opera1,
  output logic [B_W-1:0] md_opera2,
  output logic           md_muordi,
  output logic           md_start,
  output logic           md_reset,
  input  logic [R_W-1:0] md_result,
  input  logic           md_valid,
  output logic           rsp_valid,
  input  logic           rsp_ready,
  output logic [R_W-1:0] rsp_result,
  output logic           rsp_op,
  output logic           rsp_err,
  output logic           busy
);

  localparam int WD_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  state_e          state_q,      state_d;
  logic [A_W-1:0]  opera1_q,     opera1_d;
  logic [B_W-1:0]  opera2_q,     opera2_d;
  logic            muordi_q,     muordi_d;
  logic [WD_W-1:0] wd_cnt_q,     wd_cnt_d;
  logic [R_W-1:0]  rsp_result_q, rsp_result_d;
  logic            rsp_op_q,     rsp_op_d;
  logic            rsp_err_q,    rsp_err_d;

  req_t            push_req;
  req_t            head_req;
  logic [REQ_W-1:0] head_raw;
  logic            head_valid;
  logic            fifo_pop;

  assign push_req = '{a: req_a, b: req_b, op: req_op};
  assign head_req = head_raw;

  muldiv_req_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (REQ_W)
  ) u_req_fifo (
    .clock      (clock),
    .reset      (reset),
    .push_valid (req_valid),
    .push_ready (req_ready),
    .push_data  (push_req),
    .pop_valid  (head_valid),
    .pop_en     (fifo_pop),
    .pop_data   (head_raw)
  );

  always_comb begin
    state_d      = state_q;
    opera1_d     = opera1_q;
    opera2_d     = opera2_q;
    muordi_d     = muordi_q;
    wd_cnt_d     = wd_cnt_q;
    rsp_result_d = rsp_result_q;
    rsp_op_d     = rsp_op_q;
    rsp_err_d    = rsp_err_q;
    fifo_pop     = 1'b0;

    case (state_q)
      IDLE: begin
        if (head_valid) begin
          fifo_pop = 1'b1;
          opera1_d = head_req.a;
          opera2_d = head_req.b;
          muordi_d = head_req.op;
          state_d  = CLR;
        end
      end
      CLR:   state_d = LOAD;
      LOAD:  state_d = START;
      START: begin
        wd_cnt_d = '0;
        state_d  = WAIT;
      end
      WAIT: begin
        // A result arriving on the final watchdog cycle is still taken as a success.
        if (md_valid) begin
          rsp_result_d = md_result;
          rsp_op_d     = muordi_q;
          rsp_err_d    = 1'b0;
          state_d      = RESP;
        end else if (wd_cnt_q == WD_W'(TIMEOUT - 1)) begin
          rsp_result_d = '0;
          rsp_op_d     = muordi_q;
          rsp_err_d    = 1'b1;
          state_d      = RESP;
        end else begin
          wd_cnt_d = wd_cnt_q + WD_W'(1);
        end
      end
      RESP: begin
        if (rsp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= IDLE;
      opera1_q     <= '0;
      opera2_q     <= '0;
      muordi_q     <= 1'b0;
      wd_cnt_q     <= '0;
      rsp_result_q <= '0;
      rsp_op_q     <= 1'b0;
      rsp_err_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      opera1_q     <= opera1_d;
      opera2_q     <= opera2_d;
      muordi_q     <= muordi_d;
      wd_cnt_q     <= wd_cnt_d;
      rsp_result_q <= rsp_result_d;
      rsp_op_q     <= rsp_op_d;
      rsp_err_q    <= rsp_err_d;
    end
  end

  // The muldiv unit is held in reset whenever this block is, not only during CLR.
  assign md_reset   = reset | (state_q == CLR);
  assign md_start   = (state_q == START);
  assign md_opera1  = opera1_q;
  assign md_opera2  = opera2_q;
  assign md_muordi  = muordi_q;
  assign rsp_valid  = (state_q == RESP);
  assign rsp_result = rsp_result_q;
  assign rsp_op     = rsp_op_q;
  assign rsp_err    = rsp_err_q;
  assign busy       = (state_q != IDLE) | head_valid;

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Directed bench for muldiv_sequencer with a behavioural muldiv responder of configurable latency.
module tb_muldiv_sequencer;

  logic        clock = 1'b0;
  logic        reset;
  logic        req_valid, req_ready;
  logic [31:0] req_a;
  logic [63:0] req_b;
  logic        req_op;
  logic [31:0] md_opera1;
  logic [63:0] md_opera2;
  logic        md_muordi, md_start, md_reset;
  logic [63:0] md_result = '0;
  logic        md_valid  = 1'b0;
  logic        rsp_valid, rsp_ready;
  logic [63:0] rsp_result;
  logic        rsp_op, rsp_err, busy;

  int n_cmp = 0;
  int n_bad = 0;

  int model_lat  = 34;
  bit model_hang = 1'b0;
  int rem        = 0;
  logic signed [63:0] sa, sb, pend;

  always #5 clock = ~clock;

  muldiv_sequencer #(.DEPTH(4), .TIMEOUT(200)) dut (
    .clock      (clock),
    .reset      (reset),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_a      (req_a),
    .req_b      (req_b),
    .req_op     (req_op),
    .md_opera1  (md_opera1),
    .md_opera2  (md_opera2),
    .md_muordi  (md_muordi),
    .md_start   (md_start),
    .md_reset   (md_reset),
    .md_result  (md_result),
    .md_valid   (md_valid),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_result (rsp_result),
    .rsp_op     (rsp_op),
    .rsp_err    (rsp_err),
    .busy       (busy)
  );

  // Muldiv model: md_valid pulses for one cycle model_lat cycles after the md_start cycle.
  always @(negedge clock) begin
    if (md_reset) begin
      rem      = 0;
      md_valid = 1'b0;
    end else if (md_start) begin
      rem      = model_lat;
      md_valid = 1'b0;
      sa       = {{32{md_opera1[31]}}, md_opera1};
      sb       = md_opera2;
      if (md_muordi) pend = sa * sb;
      else           pend = (sa == 0) ? '1 : sb / sa;
    end else if (rem > 0) begin
      rem      = rem - 1;
      md_valid = (rem == 0) && !model_hang;
      if (md_valid) md_result = pend;
    end else begin
      md_valid = 1'b0;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "simulation time limit");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic push(input logic [31:0] a, input logic [63:0] b, input logic op);
    int n;
    n         = 0;
    req_valid = 1'b1;
    req_a     = a;
    req_b     = b;
    req_op    = op;
    while (!req_ready && n < 500) begin
      tick();
      n++;
    end
    check("push_ready", req_ready, 1);
    tick();
    req_valid = 1'b0;
  endtask

  task automatic wait_md_start();
    int n;
    n = 0;
    while (!md_start && n < 20) begin
      tick();
      n++;
    end
    check("md_start_seen", md_start, 1);
  endtask

  task automatic wait_rsp(output int n);
    n = 0;
    while (!rsp_valid && n < 400) begin
      tick();
      n++;
    end
    check("rsp_valid_seen", rsp_valid, 1);
  endtask

  task automatic accept_rsp();
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
  endtask

  initial begin
    int n;
    int pulses;
    reset     = 1'b1;
    req_valid = 1'b0;
    req_a     = '0;
    req_b     = '0;
    req_op    = 1'b0;
    rsp_ready = 1'b0;

    // Reset state
    tick();
    tick();
    check("rst_req_ready", req_ready, 1);
    check("rst_busy", busy, 0);
    check("rst_rsp_valid", rsp_valid, 0);
    check("rst_md_start", md_start, 0);
    check("rst_md_reset_held", md_reset, 1);
    reset = 1'b0;
    #1;
    check("md_reset_released", md_reset, 0);

    // 100 * 10, latency 34: single CLR pulse, md_start two cycles after the pop
    model_lat = 34;
    push(32'h64, 64'hA, 1'b1);
    check("s1_busy_queued", busy, 1);
    check("s1_idle_md_reset", md_reset, 0);
    tick();
    check("s1_clr_md_reset", md_reset, 1);
    check("s1_clr_md_start", md_start, 0);
    check("s1_opera1", md_opera1, 64'h64);
    check("s1_opera2", md_opera2, 64'hA);
    check("s1_muordi", md_muordi, 1);
    tick();
    check("s1_load_md_reset", md_reset, 0);
    check("s1_load_md_start", md_start, 0);
    tick();
    check("s1_start_md_start", md_start, 1);
    tick();
    check("s1_wait_md_start", md_start, 0);
    pulses = 0;
    n      = 0;
    while (!rsp_valid && n < 400) begin
      tick();
      n++;
      if (md_reset || md_start) pulses++;
    end
    check("s1_wait_cycles", n, 34);
    check("s1_no_extra_pulses", pulses, 0);
    check("s1_result", rsp_result, 64'h3E8);
    check("s1_err", rsp_err, 0);
    check("s1_op", rsp_op, 1);
    check("s1_opera1_stable", md_opera1, 64'h64);
    accept_rsp();
    check("s1_rsp_done", rsp_valid, 0);
    check("s1_idle_busy", busy, 0);

    // -6 * 13, latency 3: sign handled by the model, result passes through unmodified
    model_lat = 3;
    push(32'hFFFF_FFFA, 64'hD, 1'b1);
    wait_rsp(n);
    check("s2_push_to_rsp", n, 7);
    check("s2_result", rsp_result, 64'hFFFF_FFFF_FFFF_FFB2);
    check("s2_op", rsp_op, 1);
    check("s2_err", rsp_err, 0);
    accept_rsp();

    // Divide: 100 / 7
    push(32'h7, 64'd100, 1'b0);
    wait_rsp(n);
    check("div_result", rsp_result, 64'hE);
    check("div_op", rsp_op, 0);
    accept_rsp();

    // Response back-pressure plus a full queue: 3*5 held in RESP while 5 requests arrive
    model_lat = 2;
    push(32'h3, 64'h5, 1'b1);
    wait_rsp(n);
    for (int i = 1; i <= 4; i++) push(32'(i), 64'h1000, 1'b1);
    check("full_req_ready", req_ready, 0);
    req_valid = 1'b1;
    req_a     = 32'h5;
    req_b     = 64'h1000;
    req_op    = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      check("hold_rsp_valid", rsp_valid, 1);
      check("hold_rsp_result", rsp_result, 64'hF);
      check("hold_no_md_pulse", {md_reset, md_start}, 2'b00);
      check("hold_req_ready", req_ready, 0);
    end
    check("hold_rsp_op", rsp_op, 1);
    check("hold_rsp_err", rsp_err, 0);
    rsp_ready = 1'b1;
    tick();
    check("full_on_pop_cycle", req_ready, 0);
    tick();
    check("no_push_when_full", req_ready, 1);
    tick();
    req_valid = 1'b0;
    for (int i = 1; i <= 5; i++) begin
      wait_rsp(n);
      check("order_result", rsp_result, 64'(i) * 64'h1000);
      tick();
    end
    rsp_ready = 1'b0;
    tick();
    check("order_drained_busy", busy, 0);

    // Muldiv never answers: watchdog abandons after 200 WAIT cycles
    model_hang = 1'b1;
    push(32'h1, 64'h1, 1'b1);
    wait_md_start();
    tick();
    wait_rsp(n);
    check("to_wait_cycles", n, 200);
    check("to_err", rsp_err, 1);
    check("to_result", rsp_result, 64'h0);
    check("to_op", rsp_op, 1);
    accept_rsp();
    model_hang = 1'b0;

    // md_valid on the last watchdog cycle wins over the timeout
    model_lat = 200;
    push(32'h2, 64'h3, 1'b1);
    wait_md_start();
    tick();
    wait_rsp(n);
    check("tie_wait_cycles", n, 200);
    check("tie_err", rsp_err, 0);
    check("tie_result", rsp_result, 64'h6);
    accept_rsp();

    // Reset in WAIT with two requests queued
    model_lat = 50;
    rsp_ready = 1'b1;
    push(32'h9, 64'h9, 1'b1);
    wait_md_start();
    tick();
    push(32'h4, 64'h4, 1'b1);
    push(32'h5, 64'h5, 1'b1);
    tick();
    reset = 1'b1;
    #1;
    check("rst_md_reset_comb", md_reset, 1);
    tick();
    check("rst2_rsp_valid", rsp_valid, 0);
    check("rst2_rsp_result", rsp_result, 64'h0);
    check("rst2_rsp_op", rsp_op, 0);
    check("rst2_rsp_err", rsp_err, 0);
    check("rst2_md_start", md_start, 0);
    check("rst2_opera1", md_opera1, 64'h0);
    check("rst2_opera2", md_opera2, 64'h0);
    check("rst2_muordi", md_muordi, 0);
    check("rst2_busy", busy, 0);
    check("rst2_req_ready", req_ready, 1);
    reset = 1'b0;
    pulses = 0;
    for (int i = 0; i < 80; i++) begin
      tick();
      if (rsp_valid || md_start) pulses++;
    end
    check("rst2_no_activity", pulses, 0);
    check("rst2_busy_after", busy, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
